// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: next-PC select codes, branch types and fetch FSM states shared with the decoder
package fetch_pc_unit_pkg;
  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_JIMM = 2'b01;
  localparam logic [1:0] PC_SEL_JREG = 2'b10;
  localparam logic [2:0] BR_ALWAYS = 3'b000;
  localparam logic [2:0] BR_Z      = 3'b001;
  localparam logic [2:0] BR_NZ     = 3'b010;
  localparam logic [2:0] BR_C      = 3'b011;
  localparam logic [2:0] BR_V      = 3'b100;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, ISSUED} state_t;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: resolves whether a branch is taken from its type and the ALU flags
module branch_cond_eval
  import fetch_pc_unit_pkg::*;
(
  input  logic       br_en,
  input  logic [2:0] br_type,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_v,
  output logic       taken
);
  // the ternary keeps an undriven br_type from leaking into taken when br_en is low
  always_comb taken = br_en ? ((br_type == BR_ALWAYS) |
                               ((br_type == BR_Z) & flag_z) |
                               ((br_type == BR_NZ) & ~flag_z) |
                               ((br_type == BR_C) & flag_c) |
                               ((br_type == BR_V) & flag_v)) : 1'b0;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: holds the PC, fetches one word per instruction and selects the next PC on retire
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  function_val,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic [1:0]  pc_sel,
  input  logic        br_en,
  input  logic [2:0]  br_type,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_v,
  input  logic [31:0] reg_target,
  output logic        addr_err
);
  state_t state, state_nxt;
  logic fetch_done, fire, taken;
  logic [31:0] br_off, pc_nxt;
  branch_cond_eval u_cond (
    .br_en(br_en), .br_type(br_type), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .taken(taken)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH_REQ;
    else state <= state_nxt;
  always_comb begin
    fetch_done = imem_req & imem_ack & (state != ISSUED);
    fire = (state == ISSUED) & retire;
    state_nxt = fetch_done ? ISSUED : fire ? FETCH_REQ : (state == FETCH_REQ) ? FETCH_WAIT : state;
  end
  always_comb begin
    instr_valid = state == ISSUED;
    imem_addr = pc;
    pc_plus4 = pc + 32'd4;
    opcode = instr[31:26];
    function_val = instr[5:0];
  end
  always_comb begin
    br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    pc_nxt = (pc_sel == PC_SEL_JIMM) ? {pc_plus4[31:28], instr[25:0], 2'b00} :
             (pc_sel == PC_SEL_JREG) ? {reg_target[31:2], 2'b00} :
             taken ? pc_plus4 + br_off : pc_plus4;
  end
  // imem_req is registered so it rises on the edge that enters FETCH_WAIT and falls on the ack edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      instr <= '0;
      imem_req <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      imem_req <= state_nxt == FETCH_WAIT;
      if (fetch_done) instr <= imem_rdata;
      if (fire) pc <= pc_nxt;
      addr_err <= fire & (pc_sel == PC_SEL_JREG) & (|reg_target[1:0]);
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed fetch/retire sequence with hand-computed next-PC values
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, instr, pc, pc_plus4, reg_target = '0;
  logic [5:0] opcode, function_val;
  logic instr_valid, retire = 1'b0, br_en = 1'b0, flag_z = 1'b0, flag_c = 1'b0, flag_v = 1'b0, addr_err;
  logic [1:0] pc_sel = 2'b00;
  logic [2:0] br_type = 3'b000;
  int errors = 0;
  int checks = 0;
  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode), .function_val(function_val),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .retire(retire), .pc_sel(pc_sel),
    .br_en(br_en), .br_type(br_type), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .reg_target(reg_target), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    chk("req", imem_req, 1);
    chk("addr", imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, exp_addr);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = '0;
    chk("valid", instr_valid, 1);
    chk("instr", instr, word);
    chk("opcode", opcode, {26'd0, word[31:26]});
    chk("function", function_val, {26'd0, word[5:0]});
    chk("req_drop", imem_req, 0);
  endtask
  task automatic do_retire(input logic [1:0] sel, input logic ben, input logic [2:0] bt,
                           input logic z, input logic c, input logic v, input logic [31:0] rt,
                           input logic [31:0] exp_pc, input logic exp_err);
    pc_sel = sel; br_en = ben; br_type = bt; flag_z = z; flag_c = c; flag_v = v; reg_target = rt;
    retire = 1'b1;
    tick();
    retire = 1'b0; pc_sel = 2'b00; br_en = 1'b0; br_type = 3'bxxx;
    flag_z = 1'b0; flag_c = 1'b0; flag_v = 1'b0;
    chk("retire_valid", instr_valid, 0);
    chk("next_pc", pc, exp_pc);
    chk("addr_err", addr_err, {31'd0, exp_err});
    tick();
    chk("addr_err_clr", addr_err, 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", addr_err, 0);
    rst_n = 1'b1;
    tick();
    chk("first_req", imem_req, 1);
    fetch(32'h0, 32'h8C22_0004, 0);
    do_retire(2'b00, 1'b0, 3'bxxx, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0);
    fetch(32'h4, 32'h1234_5678, 0);
    do_retire(2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0, 32'h8, 1'b0);
    fetch(32'h8, 32'h1234_5678, 3);
    do_retire(2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 1'b0);
    fetch(32'h100, 32'h1000_FFFE, 0);
    do_retire(2'b00, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFC, 1'b0);
    fetch(32'hFC, 32'h0, 0);
    do_retire(2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 1'b0);
    fetch(32'h100, 32'h1000_FFFE, 1);
    do_retire(2'b00, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h104, 1'b0);
    fetch(32'h104, 32'h1400_0003, 0);
    do_retire(2'b00, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h114, 1'b0);
    fetch(32'h114, 32'h1400_0001, 0);
    do_retire(2'b11, 1'b1, 3'b101, 1'b1, 1'b1, 1'b1, 32'h0, 32'h118, 1'b0);
    fetch(32'h118, 32'h1400_0002, 0);
    do_retire(2'b00, 1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 32'h0, 32'h124, 1'b0);
    fetch(32'h124, 32'h1400_FFFF, 0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("idle_ack_instr", instr, 32'h1400_FFFF);
    chk("idle_ack_valid", instr_valid, 1);
    do_retire(2'b00, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 32'h0, 32'h124, 1'b0);
    fetch(32'h124, 32'h1400_FFFF, 0);
    do_retire(2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1000_0040, 32'h1000_0040, 1'b0);
    retire = 1'b1;
    pc_sel = 2'b10;
    reg_target = 32'h0000_0800;
    tick();
    retire = 1'b0;
    pc_sel = 2'b00;
    chk("stray_retire_pc", pc, 32'h1000_0040);
    chk("stray_retire_valid", instr_valid, 0);
    fetch(32'h1000_0040, 32'h0800_0010, 0);
    chk("link", pc_plus4, 32'h1000_0044);
    do_retire(2'b01, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1000_0040, 1'b0);
    fetch(32'h1000_0040, 32'h0800_0010, 0);
    do_retire(2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h203, 32'h200, 1'b1);
    fetch(32'h200, 32'h0, 0);
    do_retire(2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    fetch(32'hFFFF_FFFC, 32'h0, 0);
    chk("wrap_link", pc_plus4, 32'h0);
    do_retire(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    fetch(32'h0, 32'h8C22_0004, 0);
    do_retire(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0);
    chk("pre_rst_req", imem_req, 1);
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_pc", pc, 32'h0);
    tick();
    imem_ack = 1'b0;
    rst_n = 1'b1;
    chk("rst_instr_discard", instr, 32'h0);
    chk("rst_valid2", instr_valid, 0);
    tick();
    chk("rerun_req", imem_req, 1);
    fetch(32'h0, 32'h8C22_0004, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
